frac_lut4_cfg_loader: RTL and testbench
=======================================

Name: frac_lut4_cfg_loader

Overview:
Configuration controller for a chain of frac_lut4 tiles. It accepts the configuration bitstream as parallel words over a valid/ready handshake and serializes it onto the configuration flip-flop chain that holds each tile's 16 sram bits and 1 mode bit. It sits between the fabric programming interface and the ccff chain head, and reports completion and protocol errors.

Parameters:
NUM_LUT, 4, number of frac_lut4 tiles on the chain
BITS_PER_LUT, 17, config bits per tile (16 sram + 1 mode)
WORD_W, 8, input word width; CHAIN_LEN = NUM_LUT*BITS_PER_LUT (68 by default)

Ports:
prog_clk  input  1  programming clock; all state on rising edge
pReset_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a load (honoured only in IDLE)
abort  input  1  terminates the load and returns to IDLE
in_valid  input  1  in_data valid
in_data  input  WORD_W  config word; bit 0 is shifted first
in_ready  output  1  loader can accept a word
ccff_head  output  1  serial data into the chain head
ccff_en  output  1  chain shift enable; chain samples ccff_head on the edge where ccff_en=1
busy  output  1  state is LOAD or SHIFT
cfg_done  output  1  full chain loaded; sticky until next start
err_overrun  output  1  sticky; word offered after completion

Behaviour:
- Reset (pReset_n=0, async): state=IDLE, shreg=0, bit_cnt=0, word_left=0. All outputs 0: in_ready, ccff_head, ccff_en, busy, cfg_done, err_overrun.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are decoded from registers only; no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> LOAD; clear bit_cnt, cfg_done, err_overrun.
  - in_valid=1 with cfg_done=1 (and no start) -> set err_overrun. No other effect.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready: shreg<=in_data; word_left<=min(WORD_W, CHAIN_LEN-bit_cnt); -> SHIFT.
  - Unused high bits of a partial final word are discarded. Default: last word uses bits [3:0], i.e. 9 words for 68 bits.
- SHIFT:
  - in_ready=0, ccff_en=1, ccff_head=shreg[0].
  - Each cycle: shreg>>=1, bit_cnt+=1, word_left-=1.
  - When word_left reaches 1 this cycle: bit_cnt+1==CHAIN_LEN -> DONE, else -> LOAD.
- DONE: one cycle with busy=0 and cfg_done=1 -> IDLE. cfg_done stays 1 in IDLE.
- Ordering: the first bit shifted ends at the chain tail, which is the last tile's highest config bit.
- Throughput: with in_valid held high, each full word takes 1 LOAD cycle plus WORD_W SHIFT cycles. Default total from start edge to DONE is 9+68=77 cycles.
- abort: any state -> IDLE next edge. Takes priority over every other transition. ccff_en drops immediately (registered next cycle). cfg_done=0, err_overrun unchanged. Chain contents are undefined.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- in_valid is ignored outside LOAD, except for the overrun check in IDLE.
- in_valid may drop mid-load; LOAD waits indefinitely with ccff_en=0, so the chain holds.
- Reset mid-shift: immediate return to reset values; a partially shifted chain is not flagged.
- bit_cnt width: clog2(CHAIN_LEN+1). It never exceeds CHAIN_LEN.

Test Plan:
- Reset, then start with 9 words 0xA5,0x3C,... and in_valid always 1 -> 68 ccff_en cycles. ccff_head sequence equals the LSB-first concatenation truncated to 68 bits. cfg_done=1 exactly 77 cycles after the start edge. A 68-bit model chain matches.
- Same load with in_valid toggling 1/0 every other word -> ccff_en=0 during the gaps. Identical chain contents; cfg_done asserts later.
- Final word 0xF7 -> only bits 0111 are shifted. Total ccff_en count = 68, not 72.
- After cfg_done, assert in_valid with 0x55 -> err_overrun=1, in_ready=0, no ccff_en. The next start clears err_overrun and cfg_done.
- abort during the 3rd word's SHIFT at bit 2 -> next cycle state IDLE, ccff_en=0, busy=0, cfg_done=0. A subsequent start reloads correctly in 77 cycles.
- pReset_n pulsed low asynchronously mid-SHIFT -> all outputs 0 without waiting for a clock edge. start after release behaves as from a fresh reset.

Source files
------------

// File: rtl/frac_lut4_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : frac_lut4_cfg_loader_if
// Description : Programming-side bus of the frac_lut4 configuration loader:
//               load control pulses plus the valid/ready word handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface frac_lut4_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              abort;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  // Programming source side
  modport master (
    output start,
    output abort,
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Loader side
  modport slave (
    input  start,
    input  abort,
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/frac_lut4_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : frac_lut4_cfg_loader
// Description : Accepts configuration words over a valid/ready handshake and
//               serializes them LSB-first onto the frac_lut4 ccff chain.
//               Reports completion and words offered after completion.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_lut4_cfg_loader #(
  parameter int NUM_LUT      = 4,
  parameter int BITS_PER_LUT = 17,
  parameter int WORD_W       = 8
) (
  input  logic                        prog_clk,
  input  logic                        pReset_n,
  frac_lut4_cfg_loader_if.slave       cfg,
  output logic                        ccff_head,
  output logic                        ccff_en,
  output logic                        busy,
  output logic                        cfg_done,
  output logic                        err_overrun
);

  localparam int CHAIN_LEN = NUM_LUT * BITS_PER_LUT;
  localparam int BC_W      = $clog2(CHAIN_LEN + 1);
  localparam int WL_W      = $clog2(WORD_W + 1);

  localparam logic [BC_W-1:0] CHAIN_LEN_C = BC_W'(CHAIN_LEN);
  localparam logic [BC_W-1:0] WORD_W_BC   = BC_W'(WORD_W);
  localparam logic [WL_W-1:0] WORD_W_WL   = WL_W'(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q,       state_d;
  logic [WORD_W-1:0] shreg_q,       shreg_d;
  logic [BC_W-1:0]   bit_cnt_q,     bit_cnt_d;
  logic [WL_W-1:0]   word_left_q,   word_left_d;
  logic              cfg_done_q,    cfg_done_d;
  logic              err_overrun_q, err_overrun_d;

  // Bits still owed to the chain; the final word is clipped to this count so
  // its unused high bits never reach the chain.
  logic [BC_W-1:0]   bits_remaining;
  logic [WL_W-1:0]   word_len;
  logic [BC_W-1:0]   bit_cnt_inc;

  assign bits_remaining = CHAIN_LEN_C - bit_cnt_q;
  assign word_len       = (bits_remaining >= WORD_W_BC) ? WORD_W_WL
                                                        : WL_W'(bits_remaining);
  assign bit_cnt_inc    = bit_cnt_q + BC_W'(1);

  // Next-state and register update decode; abort overrides every transition
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    word_left_d   = word_left_q;
    cfg_done_d    = cfg_done_q;
    err_overrun_d = err_overrun_q;

    if (cfg.abort) begin
      state_d    = ST_IDLE;
      cfg_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg.start) begin
            state_d       = ST_LOAD;
            bit_cnt_d     = '0;
            cfg_done_d    = 1'b0;
            err_overrun_d = 1'b0;
          end else if (cfg.in_valid && cfg_done_q) begin
            err_overrun_d = 1'b1;
          end
        end
        ST_LOAD: begin
          if (cfg.in_valid) begin
            shreg_d     = cfg.in_data;
            word_left_d = word_len;
            state_d     = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_d     = shreg_q >> 1;
          bit_cnt_d   = bit_cnt_inc;
          word_left_d = word_left_q - WL_W'(1);
          if (word_left_q == WL_W'(1)) begin
            if (bit_cnt_inc == CHAIN_LEN_C) begin
              state_d    = ST_DONE;
              cfg_done_d = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      word_left_q   <= '0;
      cfg_done_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      word_left_q   <= word_left_d;
      cfg_done_q    <= cfg_done_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  assign cfg.in_ready = (state_q == ST_LOAD);
  assign ccff_en      = (state_q == ST_SHIFT);
  assign ccff_head    = (state_q == ST_SHIFT) & shreg_q[0];
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign cfg_done     = cfg_done_q;
  assign err_overrun  = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_lut4_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frac_lut4_cfg_loader
// Description : Directed self-checking bench for frac_lut4_cfg_loader with a
//               68-bit model of the ccff chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frac_lut4_cfg_loader;

  logic prog_clk = 1'b0;
  logic pReset_n = 1'b0;
  logic ccff_head, ccff_en, busy, cfg_done, err_overrun;

  frac_lut4_cfg_loader_if #(.WORD_W(8)) cfg ();

  frac_lut4_cfg_loader #(
    .NUM_LUT      (4),
    .BITS_PER_LUT (17),
    .WORD_W       (8)
  ) dut (
    .prog_clk    (prog_clk),
    .pReset_n    (pReset_n),
    .cfg         (cfg),
    .ccff_head   (ccff_head),
    .ccff_en     (ccff_en),
    .busy        (busy),
    .cfg_done    (cfg_done),
    .err_overrun (err_overrun)
  );

  always #5 prog_clk = ~prog_clk;

  logic [7:0]  words [9];
  logic [67:0] chain;
  logic [67:0] exp_chain;
  int          en_cnt;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"},  cfg.in_ready, 0);
    check_eq({tag, "_head"},      ccff_head,    0);
    check_eq({tag, "_en"},        ccff_en,      0);
    check_eq({tag, "_busy"},      busy,         0);
    check_eq({tag, "_done"},      cfg_done,     0);
    check_eq({tag, "_overrun"},   err_overrun,  0);
  endtask

  // Runs one load from IDLE. stop_at >= 0 interrupts while chain bit stop_at
  // is on ccff_head, by abort or (use_reset) by an async reset pulse.
  task automatic run_load(input bit gap, input int stop_at, input bit use_reset,
                          input int exp_cyc);
    int widx;
    int pause;
    int cyc;
    bit done;
    widx   = 0;
    pause  = 0;
    cyc    = 0;
    done   = 0;
    chain  = '0;
    en_cnt = 0;
    cfg.start    = 1'b1;
    cfg.in_valid = 1'b0;
    @(negedge prog_clk);
    cfg.start = 1'b0;
    check_eq("start_busy",     busy,        1);
    check_eq("start_done_clr", cfg_done,    0);
    check_eq("start_ovr_clr",  err_overrun, 0);
    while (!done && cyc < 400) begin
      if (ccff_en) begin
        chain = {chain[66:0], ccff_head};
        en_cnt++;
      end
      if (cfg_done) begin
        done = 1;
      end else if (stop_at >= 0 && ccff_en && en_cnt == stop_at + 1) begin
        cfg.in_valid = 1'b0;
        if (use_reset) begin
          #2 pReset_n = 1'b0;
          #1;
          check_all_zero("async_rst");
          @(negedge prog_clk);
          pReset_n = 1'b1;
        end else begin
          cfg.abort = 1'b1;
          @(negedge prog_clk);
          cfg.abort = 1'b0;
          check_eq("abort_en",       ccff_en,      0);
          check_eq("abort_busy",     busy,         0);
          check_eq("abort_done",     cfg_done,     0);
          check_eq("abort_in_ready", cfg.in_ready, 0);
        end
        return;
      end else begin
        if (cfg.in_ready && gap && pause > 0) begin
          cfg.in_valid = 1'b0;
          pause--;
          check_eq("gap_hold_en", ccff_en, 0);
        end else if (widx < 9) begin
          cfg.in_valid = 1'b1;
          cfg.in_data  = words[widx];
        end else begin
          cfg.in_valid = 1'b0;
        end
        if (cfg.in_ready && cfg.in_valid) begin
          widx++;
          pause = gap ? 3 : 0;
        end
        @(negedge prog_clk);
        cyc++;
      end
    end
    cfg.in_valid = 1'b0;
    check_eq("done_cycle",  cyc,    exp_cyc);
    check_eq("en_count",    en_cnt, 68);
    check_eq("chain",       chain,  exp_chain);
    check_eq("done_busy",   busy,   0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    cfg.start    = 1'b0;
    cfg.abort    = 1'b0;
    cfg.in_valid = 1'b0;
    cfg.in_data  = '0;
    words = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h69, 8'h96, 8'hF7};
    // Bit k of the LSB-first stream ends at chain position 67-k
    for (int k = 0; k < 68; k++) begin
      exp_chain[67-k] = words[k/8][k%8];
    end

    #12;
    check_all_zero("reset");
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // Back-to-back words: 9 LOAD + 68 SHIFT cycles
    run_load(0, -1, 0, 77);
    @(negedge prog_clk);
    check_eq("done_sticky",   cfg_done, 1);
    check_eq("idle_busy",     busy,     0);

    // Word offered after completion flags an overrun and is not shifted
    cfg.in_valid = 1'b1;
    cfg.in_data  = 8'h55;
    @(negedge prog_clk);
    cfg.in_valid = 1'b0;
    check_eq("overrun_flag",     err_overrun,  1);
    check_eq("overrun_in_ready", cfg.in_ready, 0);
    check_eq("overrun_en",       ccff_en,      0);

    // Three idle LOAD cycles before each of words 2..9: 77 + 24
    run_load(1, -1, 0, 101);
    @(negedge prog_clk);

    // Abort on bit 2 of the third word, then a clean reload
    run_load(0, 18, 0, 0);
    run_load(0, -1, 0, 77);
    @(negedge prog_clk);

    // Async reset mid-shift, then a clean reload
    run_load(0, 30, 1, 0);
    run_load(0, -1, 0, 77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
